// File: rtl/temp_rx_pkg.sv
// Shared defaults and types for the temperature-sensor frame receiver.
package temp_rx_pkg;

   localparam int DATA_W      = 20;
   localparam int SYNC_STAGES = 2;
   localparam int GUARD_BITS  = 4;
   localparam int TIMEOUT_CYC = 4096;

   localparam logic START_BIT = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      GUARD = 2'd2
   } rx_state_t;

endpackage

// File: rtl/temp_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with a registered
// previous value so the caller gets a clean falling-edge pulse.
module temp_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic counter_clk,
   input  logic count_20_reset,
   input  logic i_async,
   output logic o_level,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   // Shift the raw input through the synchronizer and keep the last synced value.
   always_ff @(posedge counter_clk or posedge count_20_reset) begin
      if (count_20_reset) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   // A reset-time high input rises from the cleared flops, so it never looks like a fall.
   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_fall  = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/temp_frame_rx.sv
// Temperature-sensor serial frame receiver: start bit '1', DATA_W bits
// LSB-first, idle-low line. Bits are taken on the synchronized falling edge
// of ser_clk_in (mid-bit) and the finished word is strobed out one cycle
// after the last bit is shifted in.
//
//   state | meaning
//   IDLE  | waiting for a start bit sample while enabled
//   RECV  | shifting payload bits, watchdog armed
//   GUARD | frame done, waiting for GUARD_BITS consecutive zero samples
module temp_frame_rx
   import temp_rx_pkg::*;
#(
   parameter int DATA_W      = temp_rx_pkg::DATA_W,
   parameter int SYNC_STAGES = temp_rx_pkg::SYNC_STAGES,
   parameter int GUARD_BITS  = temp_rx_pkg::GUARD_BITS,
   parameter int TIMEOUT_CYC = temp_rx_pkg::TIMEOUT_CYC
) (
   input  logic              counter_clk,
   input  logic              count_20_reset,
   input  logic              ser_clk_in,
   input  logic              ser_data_in,
   input  logic              enable,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              frame_err,
   output logic [7:0]        frame_cnt,
   output logic              busy
);

   localparam int BIT_CNT_W  = $clog2(DATA_W);
   localparam int ZERO_CNT_W = $clog2(GUARD_BITS + 1);
   localparam int IDLE_CNT_W = $clog2(TIMEOUT_CYC);

   logic w_clk_lvl, w_clk_fall;
   logic w_data_lvl, w_data_fall;
   logic w_unused_sync;

   temp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
      .counter_clk    (counter_clk),
      .count_20_reset (count_20_reset),
      .i_async        (ser_clk_in),
      .o_level        (w_clk_lvl),
      .o_fall         (w_clk_fall)
   );

   temp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
      .counter_clk    (counter_clk),
      .count_20_reset (count_20_reset),
      .i_async        (ser_data_in),
      .o_level        (w_data_lvl),
      .o_fall         (w_data_fall)
   );

   // Only the clock edge and the data level carry meaning here.
   assign w_unused_sync = w_clk_lvl | w_data_fall;

   rx_state_t               r_state, w_state_nxt;
   logic [DATA_W-1:0]       r_shreg, w_shreg_nxt;
   logic [BIT_CNT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
   logic [ZERO_CNT_W-1:0]   r_zero_cnt, w_zero_cnt_nxt;
   logic [IDLE_CNT_W-1:0]   r_idle_cnt, w_idle_cnt_nxt;
   logic                    r_done, w_done_nxt;
   logic [DATA_W-1:0]       r_data_out, w_data_nxt;
   logic                    r_valid, w_valid_nxt;
   logic                    r_err, w_err_nxt;
   logic [7:0]              r_frame_cnt, w_frame_cnt_nxt;

   logic w_sample, w_bit;
   assign w_sample = w_clk_fall;
   assign w_bit    = w_data_lvl;

   // Next-state, datapath and strobe decode.
   always_comb begin
      w_state_nxt     = r_state;
      w_shreg_nxt     = r_shreg;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_zero_cnt_nxt  = r_zero_cnt;
      w_idle_cnt_nxt  = r_idle_cnt;
      w_done_nxt      = 1'b0;
      w_err_nxt       = 1'b0;
      w_valid_nxt     = r_done & enable;
      w_data_nxt      = r_data_out;
      w_frame_cnt_nxt = r_frame_cnt;

      if (w_valid_nxt) begin
         w_data_nxt      = r_shreg;
         w_frame_cnt_nxt = r_frame_cnt + 8'd1;
      end

      unique case (r_state)
         IDLE: begin
            if (w_sample && (w_bit == START_BIT) && enable) begin
               w_state_nxt    = RECV;
               w_bit_cnt_nxt  = '0;
               w_shreg_nxt    = '0;
               w_idle_cnt_nxt = IDLE_CNT_W'(TIMEOUT_CYC - 1);
            end
         end
         RECV: begin
            if (!enable) begin
               w_state_nxt = IDLE;
            end else if (w_sample) begin
               // A sample in the terminal-count cycle still counts; the watchdog reloads.
               w_shreg_nxt    = {w_bit, r_shreg[DATA_W-1:1]};
               w_idle_cnt_nxt = IDLE_CNT_W'(TIMEOUT_CYC - 1);
               if (r_bit_cnt == BIT_CNT_W'(DATA_W - 1)) begin
                  w_state_nxt    = GUARD;
                  w_zero_cnt_nxt = '0;
                  w_done_nxt     = 1'b1;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
               end
            end else if (r_idle_cnt == '0) begin
               w_state_nxt = IDLE;
               w_err_nxt   = 1'b1;
            end else begin
               w_idle_cnt_nxt = r_idle_cnt - IDLE_CNT_W'(1);
            end
         end
         GUARD: begin
            if (!enable) begin
               w_state_nxt = IDLE;
            end else if (w_sample) begin
               if (w_bit == 1'b0) begin
                  if (r_zero_cnt == ZERO_CNT_W'(GUARD_BITS - 1)) begin
                     w_state_nxt    = IDLE;
                     w_zero_cnt_nxt = '0;
                  end else begin
                     w_zero_cnt_nxt = r_zero_cnt + ZERO_CNT_W'(1);
                  end
               end else begin
                  // Line still carries data: flag it and restart the quiet-period count.
                  w_err_nxt      = ~r_done;
                  w_zero_cnt_nxt = '0;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge counter_clk or posedge count_20_reset) begin
      if (count_20_reset) begin
         r_state     <= IDLE;
         r_shreg     <= '0;
         r_bit_cnt   <= '0;
         r_zero_cnt  <= '0;
         r_idle_cnt  <= '0;
         r_done      <= 1'b0;
         r_data_out  <= '0;
         r_valid     <= 1'b0;
         r_err       <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_shreg     <= w_shreg_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_zero_cnt  <= w_zero_cnt_nxt;
         r_idle_cnt  <= w_idle_cnt_nxt;
         r_done      <= w_done_nxt;
         r_data_out  <= w_data_nxt;
         r_valid     <= w_valid_nxt;
         r_err       <= w_err_nxt;
         r_frame_cnt <= w_frame_cnt_nxt;
      end
   end

   assign data_out   = r_data_out;
   assign data_valid = r_valid;
   assign frame_err  = r_err;
   assign frame_cnt  = r_frame_cnt;
   assign busy       = (r_state == RECV);

endmodule

// File: tb/tb_temp_frame_rx.sv
// Self-checking bench for temp_frame_rx: frames are generated bit-by-bit on the
// pins and compared against a frame-level model (queue of expected payloads,
// modulo-256 good-frame count).
module tb_temp_frame_rx;

   localparam int DATA_W = 20;
   localparam int SYNC   = 2;
   localparam int GBITS  = 4;
   localparam int TMO    = 4096;

   logic              counter_clk = 1'b0;
   logic              count_20_reset;
   logic              ser_clk_in;
   logic              ser_data_in;
   logic              enable;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              frame_err;
   logic [7:0]        frame_cnt;
   logic              busy;

   temp_frame_rx dut (
      .counter_clk    (counter_clk),
      .count_20_reset (count_20_reset),
      .ser_clk_in     (ser_clk_in),
      .ser_data_in    (ser_data_in),
      .enable         (enable),
      .data_out       (data_out),
      .data_valid     (data_valid),
      .frame_err      (frame_err),
      .frame_cnt      (frame_cnt),
      .busy           (busy)
   );

   always #5 counter_clk = ~counter_clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int half = 8;
   int n_valid = 0, n_err = 0, n_both = 0;
   int valid_cyc = 0, err_cyc = 0, fall_cyc = 0, data_fall_cyc = 0;

   logic [DATA_W-1:0] q_got[$];
   logic [DATA_W-1:0] q_exp[$];
   int                exp_cnt = 0;
   logic [DATA_W-1:0] last_data = '0;

   always @(posedge counter_clk) cyc <= cyc + 1;

   // Output monitor: records strobes and captured words.
   always @(negedge counter_clk) begin
      if (data_valid === 1'b1) begin
         n_valid++;
         valid_cyc = cyc;
         q_got.push_back(data_out);
      end
      if (frame_err === 1'b1) begin
         n_err++;
         err_cyc = cyc;
      end
      if (data_valid === 1'b1 && frame_err === 1'b1) n_both++;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge counter_clk);
   endtask

   task automatic send_bit(input logic b);
      ser_data_in = b;
      ser_clk_in  = 1'b1;
      wait_cyc(half);
      ser_clk_in  = 1'b0;
      fall_cyc    = cyc;
      wait_cyc(half);
   endtask

   task automatic send_payload(input logic [DATA_W-1:0] v);
      send_bit(1'b1);
      for (int i = 0; i < DATA_W; i++) send_bit(v[i]);
      data_fall_cyc = fall_cyc;
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] v);
      send_payload(v);
      repeat (GBITS) send_bit(1'b0);
   endtask

   // Frame-level reference: a good frame is queued and bumps the wrapping count.
   task automatic model_frame(input logic [DATA_W-1:0] v);
      q_exp.push_back(v);
      exp_cnt   = (exp_cnt + 1) % 256;
      last_data = v;
   endtask

   task automatic model_reset();
      q_exp.delete();
      q_got.delete();
      exp_cnt   = 0;
      last_data = '0;
   endtask

   task automatic test_reset();
      logic [DATA_W-1:0] zero_w;
      zero_w = '0;
      count_20_reset = 1'b1;
      enable         = 1'b1;
      ser_clk_in     = 1'b1;
      ser_data_in    = 1'b1;
      wait_cyc(3);
      checks++; if (data_out !== zero_w) begin errors++; $display("FAIL reset_data_out: got %h exp %h", data_out, zero_w); end
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", data_valid); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", frame_err); end
      checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d exp 0", frame_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
      count_20_reset = 1'b0;
      wait_cyc(6);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_clk_high_busy: got %b exp 0", busy); end
      ser_data_in = 1'b0;
      wait_cyc(4);
      ser_clk_in = 1'b0;
      wait_cyc(8);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_zero_sample_busy: got %b exp 0", busy); end
      checks++; if (n_valid + n_err !== 0) begin errors++; $display("FAIL reset_no_strobes: got %0d exp 0", n_valid + n_err); end
   endtask

   task automatic test_single();
      int v0, e0;
      logic [DATA_W-1:0] got, expv;
      v0 = n_valid; e0 = n_err;
      send_frame(20'h5A5A5);
      model_frame(20'h5A5A5);
      checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL single_valid_pulses: got %0d exp 1", n_valid - v0); end
      checks++; if (valid_cyc - data_fall_cyc !== SYNC + 2) begin errors++; $display("FAIL single_latency: got %0d exp %0d", valid_cyc - data_fall_cyc, SYNC + 2); end
      while (q_exp.size() > 0) begin
         expv = q_exp.pop_front();
         got  = 'x;
         if (q_got.size() > 0) got = q_got.pop_front();
         checks++; if (got !== expv) begin errors++; $display("FAIL single_data: got %h exp %h", got, expv); end
      end
      checks++; if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL single_frame_cnt: got %0d exp %0d", frame_cnt, exp_cnt); end
      checks++; if (n_err !== e0) begin errors++; $display("FAIL single_err: got %0d exp %0d", n_err, e0); end
   endtask

   task automatic test_back_to_back();
      int e0;
      logic [DATA_W-1:0] got, expv, v;
      e0 = n_err;
      send_frame(20'hFFFFF); model_frame(20'hFFFFF);
      repeat (40) send_bit(1'b0);
      send_frame(20'h00001); model_frame(20'h00001);
      for (int k = 0; k < 4; k++) begin
         v = DATA_W'($urandom);
         send_frame(v); model_frame(v);
         repeat ($urandom_range(0, 5)) send_bit(1'b0);
      end
      while (q_exp.size() > 0) begin
         expv = q_exp.pop_front();
         got  = 'x;
         if (q_got.size() > 0) got = q_got.pop_front();
         checks++; if (got !== expv) begin errors++; $display("FAIL b2b_data: got %h exp %h", got, expv); end
      end
      checks++; if (q_got.size() !== 0) begin errors++; $display("FAIL b2b_extra_frames: got %0d exp 0", q_got.size()); end
      checks++; if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL b2b_frame_cnt: got %0d exp %0d", frame_cnt, exp_cnt); end
      checks++; if (n_err !== e0) begin errors++; $display("FAIL b2b_err: got %0d exp %0d", n_err, e0); end
   endtask

   task automatic test_timeout();
      int e0, v0, last_fall;
      logic [DATA_W-1:0] got, expv;
      e0 = n_err; v0 = n_valid;
      send_bit(1'b1);
      for (int i = 0; i < 10; i++) send_bit(1'($urandom));
      last_fall = fall_cyc;
      for (int k = 0; k < TMO + 200 && n_err == e0; k++) wait_cyc(1);
      checks++;
      if (n_err == e0) begin
         errors++; $display("FAIL timeout_wait: got no frame_err within %0d cycles", TMO + 200);
      end else if (err_cyc - last_fall !== SYNC + 1 + TMO) begin
         errors++; $display("FAIL timeout_latency: got %0d exp %0d", err_cyc - last_fall, SYNC + 1 + TMO);
      end
      wait_cyc(4);
      checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL timeout_err_pulses: got %0d exp 1", n_err - e0); end
      checks++; if (data_out !== last_data) begin errors++; $display("FAIL timeout_data_kept: got %h exp %h", data_out, last_data); end
      checks++; if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL timeout_frame_cnt: got %0d exp %0d", frame_cnt, exp_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b exp 0", busy); end
      checks++; if (n_valid !== v0) begin errors++; $display("FAIL timeout_no_valid: got %0d exp %0d", n_valid, v0); end
      send_frame(20'h12345); model_frame(20'h12345);
      while (q_exp.size() > 0) begin
         expv = q_exp.pop_front();
         got  = 'x;
         if (q_got.size() > 0) got = q_got.pop_front();
         checks++; if (got !== expv) begin errors++; $display("FAIL timeout_next_data: got %h exp %h", got, expv); end
      end
   endtask

   task automatic test_guard();
      int e0;
      logic [DATA_W-1:0] got, expv, v;
      e0 = n_err;
      v  = DATA_W'($urandom);
      send_payload(v); model_frame(v);
      send_bit(1'b0);
      send_bit(1'b1);
      checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL guard_err1: got %0d exp 1", n_err - e0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL guard_no_start1: got busy %b exp 0", busy); end
      repeat (3) send_bit(1'b0);
      send_bit(1'b1);
      checks++; if (n_err - e0 !== 2) begin errors++; $display("FAIL guard_err2: got %0d exp 2", n_err - e0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL guard_no_start2: got busy %b exp 0", busy); end
      repeat (GBITS) send_bit(1'b0);
      v = DATA_W'($urandom);
      send_frame(v); model_frame(v);
      while (q_exp.size() > 0) begin
         expv = q_exp.pop_front();
         got  = 'x;
         if (q_got.size() > 0) got = q_got.pop_front();
         checks++; if (got !== expv) begin errors++; $display("FAIL guard_data: got %h exp %h", got, expv); end
      end
      checks++; if (n_err - e0 !== 2) begin errors++; $display("FAIL guard_err_total: got %0d exp 2", n_err - e0); end
      checks++; if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL guard_frame_cnt: got %0d exp %0d", frame_cnt, exp_cnt); end
   endtask

   task automatic test_reset_midframe();
      logic [DATA_W-1:0] got, expv, zero_w;
      zero_w = '0;
      send_bit(1'b1);
      for (int i = 0; i < 7; i++) send_bit(1'($urandom));
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b exp 1", busy); end
      count_20_reset = 1'b1;
      #1;
      checks++; if (data_out !== zero_w) begin errors++; $display("FAIL midreset_data_out: got %h exp 0", data_out); end
      checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL midreset_frame_cnt: got %0d exp 0", frame_cnt); end
      checks++; if (busy !== 1'b0 || data_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL midreset_strobes: got busy %b valid %b err %b exp 0 0 0", busy, data_valid, frame_err); end
      wait_cyc(2);
      count_20_reset = 1'b0;
      model_reset();
      wait_cyc(4);
      send_frame(20'hABCDE); model_frame(20'hABCDE);
      while (q_exp.size() > 0) begin
         expv = q_exp.pop_front();
         got  = 'x;
         if (q_got.size() > 0) got = q_got.pop_front();
         checks++; if (got !== expv) begin errors++; $display("FAIL midreset_next_data: got %h exp %h", got, expv); end
      end
      checks++; if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL midreset_frame_cnt_after: got %0d exp %0d", frame_cnt, exp_cnt); end
   endtask

   task automatic test_enable_drop();
      int e0, v0;
      logic [DATA_W-1:0] got, expv, v;
      e0 = n_err; v0 = n_valid;
      v  = DATA_W'($urandom);
      send_bit(1'b1);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL endrop_busy_before: got %b exp 1", busy); end
      enable = 1'b0;
      wait_cyc(1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL endrop_busy_next: got %b exp 0", busy); end
      for (int i = 8; i < DATA_W; i++) send_bit(v[i]);
      send_frame(DATA_W'($urandom));
      checks++; if (n_valid !== v0) begin errors++; $display("FAIL endrop_no_valid: got %0d exp %0d", n_valid, v0); end
      checks++; if (n_err !== e0) begin errors++; $display("FAIL endrop_no_err: got %0d exp %0d", n_err, e0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL endrop_disabled_start: got busy %b exp 0", busy); end
      enable = 1'b1;
      repeat (GBITS) send_bit(1'b0);
      v = DATA_W'($urandom);
      send_frame(v); model_frame(v);
      while (q_exp.size() > 0) begin
         expv = q_exp.pop_front();
         got  = 'x;
         if (q_got.size() > 0) got = q_got.pop_front();
         checks++; if (got !== expv) begin errors++; $display("FAIL endrop_data: got %h exp %h", got, expv); end
      end
   endtask

   task automatic test_wrap();
      logic [DATA_W-1:0] got, expv, v;
      count_20_reset = 1'b1;
      wait_cyc(2);
      count_20_reset = 1'b0;
      model_reset();
      wait_cyc(2);
      half = 4;
      for (int k = 0; k < 256; k++) begin
         v = DATA_W'($urandom);
         send_frame(v); model_frame(v);
         expv = q_exp.pop_front();
         got  = 'x;
         if (q_got.size() > 0) got = q_got.pop_front();
         checks++; if (got !== expv) begin errors++; $display("FAIL wrap_data[%0d]: got %h exp %h", k, got, expv); end
         checks++; if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL wrap_frame_cnt[%0d]: got %0d exp %0d", k, frame_cnt, exp_cnt); end
      end
      half = 8;
      checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_final: got %0d exp 0", frame_cnt); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_timeout();
      test_guard();
      test_enable_drop();
      test_reset_midframe();
      test_wrap();
      checks++; if (n_both !== 0) begin errors++; $display("FAIL valid_err_overlap: got %0d exp 0", n_both); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
